dnn_host_ctrl: RTL
==================

DNN_HOST_CTRL -- requirements
Module: dnn_host_ctrl

Interface
REQ-001 Parameter: TIMEOUT, default 15, max cycles to wait for both result strobes after in_ready.
REQ-002 Port: clk  input  1  sole clock; all logic on posedge.
REQ-003 Port: rst  input  1  synchronous, active-high reset.
REQ-004 Port: s_valid  input  1  operand word valid.
REQ-005 Port: s_ready  output  1  operand word accepted when s_valid&s_ready.
REQ-006 Port: s_data  input  5  signed two's-complement operand word.
REQ-007 Port: x_bus  output  20  x0..x3; x0 in bits [4:0].
REQ-008 Port: w_hid  output  80  w04,w14,w24,w34,w05..w35,w06..w36,w07..w37; w04 in bits [4:0].
REQ-009 Port: w_out  output  40  w48,w58,w68,w78,w49,w59,w69,w79; w48 in bits [4:0].
REQ-010 Port: in_ready  output  1  one-cycle start pulse to the DNN core.
REQ-011 Port: out0, out1  input  17 each  signed DNN results.
REQ-012 Port: out0_ready, out1_ready  input  1 each  result strobes; may arrive on different cycles.
REQ-013 Port: r_valid  output  1  result available.
REQ-014 Port: r_ready  input  1  result consumed when r_valid&r_ready.
REQ-015 Port: r_out0, r_out1  output  17 each  captured results.
REQ-016 Port: r_err  output  1  valid with r_valid; 1 = timeout, results forced to 0.

Function
REQ-017 States SHALL be LOAD, FIRE, WAIT, RESULT.
REQ-018 LOAD: s_ready=1; each accepted word goes to slot cnt (0-3 x, 4-19 w_hid, 20-27 w_out), cnt increments 0..27.
REQ-019 Accepting word 27 SHALL move to FIRE the next cycle; cnt wraps to 0.
REQ-020 FIRE lasts exactly one cycle, in_ready=1, s_ready=0, then WAIT.
REQ-021 x_bus/w_hid/w_out SHALL hold stable from FIRE until RESULT handshake completes.
REQ-022 WAIT: out0 captured on any cycle out0_ready=1, out1 on any cycle out1_ready=1; each capture sticky; later strobes for an already-captured output ignored.
REQ-023 Both captured (including same cycle) SHALL move to RESULT the next cycle with r_err=0.
REQ-024 Timer counts WAIT cycles; reaching TIMEOUT without both captures SHALL move to RESULT with r_err=1, r_out0=r_out1=0.
REQ-025 RESULT: r_valid=1, outputs stable until r_ready; handshake returns to LOAD with cnt=0, captures cleared.
REQ-026 Strobes outside WAIT SHALL be ignored; s_valid outside LOAD ignored, no word consumed.
REQ-027 Result registers store the 17-bit value verbatim; no sign or width change.

Reset
REQ-028 rst SHALL override all activity on the next edge, including mid-load, mid-WAIT and mid-RESULT.
REQ-029 Reset values: state=LOAD, cnt=0, s_ready=1 after reset, in_ready=0, r_valid=0, r_err=0, r_out0=r_out1=0, x_bus=w_hid=w_out=0.

Configuration
REQ-030 Macro DNN_HOST_TIMEOUT_EN defined: timeout per REQ-024.
REQ-031 Macro undefined: WAIT unbounded, timer absent, r_err constant 0.

Structure
REQ-032 Shared package dnn_pkg SHALL hold OP_W=5, RES_W=17, N_X=4, N_WHID=16, N_WOUT=8, N_WORDS=28 and the state enum.
REQ-033 One sub-module, dnn_operand_regfile (28x5 slot register file with flat bus outputs), is natural; FSM stays in dnn_host_ctrl.

Verification
REQ-034 Stream x=4,2,4,1; w_hid=3,2,13,-6,-9,1,-4,14,3,6,-15,15,9,-10,15,-10; w_out=0,-1,3,-11,-12,-15,-15,6 into dnn_opt_mult -> one in_ready pulse, r_out0=-726, r_out1=-348, r_err=0.
REQ-035 All 28 words = -16 -> r_out0=r_out1=-65536 (17'h10000); all words = 15 -> r_out0=r_out1=54000.
REQ-036 Bench responder: out0_ready at WAIT cycle 2, out1_ready at cycle 5 -> both captured, r_valid on cycle 6; same-cycle strobes -> r_valid the next cycle.
REQ-037 With DNN_HOST_TIMEOUT_EN, no strobes -> r_valid, r_err=1, results 0 after 15 WAIT cycles; macro undefined -> r_valid stays 0.
REQ-038 rst asserted after word 10 -> cnt=0, no in_ready; fresh 28-word stream then runs normally. r_ready held low 4 cycles -> outputs stable, s_ready=0 throughout.

Source files
------------

// File: rtl/dnn_pkg.sv
// dnn_pkg: shared widths, operand slot counts and host controller state encoding.
package dnn_pkg;
   localparam int OP_W = 5;
   localparam int RES_W = 17;
   localparam int N_X = 4;
   localparam int N_WHID = 16;
   localparam int N_WOUT = 8;
   localparam int N_WORDS = 28;
   localparam int CNT_W = $clog2(N_WORDS);
   typedef enum logic [1:0] {LOAD, FIRE, WAIT, RESULT} state_t;
endpackage

// File: rtl/dnn_operand_regfile.sv
// dnn_operand_regfile: 28 operand slots of OP_W bits, exposed as the x / hidden / output weight buses.
module dnn_operand_regfile
   import dnn_pkg::*;
(
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     we,
   input  logic [CNT_W-1:0]         addr,
   input  logic [OP_W-1:0]          wdata,
   output logic [N_X*OP_W-1:0]      x_bus,
   output logic [N_WHID*OP_W-1:0]   w_hid,
   output logic [N_WOUT*OP_W-1:0]   w_out
);
   logic [N_WORDS*OP_W-1:0] slots;
   always_ff @(posedge clk) begin
      if (rst) slots <= '0;
      else if (we) slots[addr*OP_W +: OP_W] <= wdata;
   end
   assign x_bus = slots[0 +: N_X*OP_W];
   assign w_hid = slots[N_X*OP_W +: N_WHID*OP_W];
   assign w_out = slots[(N_X+N_WHID)*OP_W +: N_WOUT*OP_W];
endmodule

// File: rtl/dnn_host_ctrl.sv
// dnn_host_ctrl: streams 28 operands into the DNN core, fires it, collects both results.
// Define DNN_HOST_TIMEOUT_EN to bound the result wait to TIMEOUT cycles (r_err flags expiry).
module dnn_host_ctrl
   import dnn_pkg::*;
#(
   parameter int TIMEOUT = 15
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     s_valid,
   output logic                     s_ready,
   input  logic [OP_W-1:0]          s_data,
   output logic [N_X*OP_W-1:0]      x_bus,
   output logic [N_WHID*OP_W-1:0]   w_hid,
   output logic [N_WOUT*OP_W-1:0]   w_out,
   output logic                     in_ready,
   input  logic [RES_W-1:0]         out0,
   input  logic [RES_W-1:0]         out1,
   input  logic                     out0_ready,
   input  logic                     out1_ready,
   output logic                     r_valid,
   input  logic                     r_ready,
   output logic [RES_W-1:0]         r_out0,
   output logic [RES_W-1:0]         r_out1,
   output logic                     r_err
);
   state_t state;
   logic [CNT_W-1:0] cnt;
   logic got0, got1, done0, done1, accept, expired;
   assign accept = s_valid & s_ready;
   assign done0 = got0 | out0_ready;
   assign done1 = got1 | out1_ready;
   dnn_operand_regfile u_regfile (
      .clk   (clk),
      .rst   (rst),
      .we    (accept),
      .addr  (cnt),
      .wdata (s_data),
      .x_bus (x_bus),
      .w_hid (w_hid),
      .w_out (w_out)
   );
`ifdef DNN_HOST_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT + 1);
   logic [TW-1:0] timer;
   assign expired = timer == TW'(TIMEOUT - 1);
   always_ff @(posedge clk) begin
      if (rst) begin
         timer <= '0;
         r_err <= 1'b0;
      end else begin
         timer <= state == WAIT ? timer + 1'b1 : '0;
         if (state == WAIT && !(done0 && done1) && expired) r_err <= 1'b1;
         else if (state == RESULT && r_ready) r_err <= 1'b0;
      end
   end
`else
   // Unbounded wait: nothing can expire, TIMEOUT only matters with the timer built in.
   assign expired = TIMEOUT < 0;
   assign r_err = 1'b0;
`endif
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= LOAD;
         cnt <= '0;
         s_ready <= 1'b1;
         in_ready <= 1'b0;
         r_valid <= 1'b0;
         r_out0 <= '0;
         r_out1 <= '0;
         got0 <= 1'b0;
         got1 <= 1'b0;
      end else begin
         in_ready <= 1'b0;
         case (state)
            LOAD: if (accept) begin
               cnt <= cnt == CNT_W'(N_WORDS - 1) ? '0 : cnt + 1'b1;
               if (cnt == CNT_W'(N_WORDS - 1)) begin
                  state <= FIRE;
                  s_ready <= 1'b0;
                  in_ready <= 1'b1;
               end
            end
            FIRE: state <= WAIT;
            WAIT: begin
               if (out0_ready && !got0) begin
                  r_out0 <= out0;
                  got0 <= 1'b1;
               end
               if (out1_ready && !got1) begin
                  r_out1 <= out1;
                  got1 <= 1'b1;
               end
               // Completion wins over expiry when both land on the last allowed cycle.
               if (done0 && done1) begin
                  state <= RESULT;
                  r_valid <= 1'b1;
               end else if (expired) begin
                  state <= RESULT;
                  r_valid <= 1'b1;
                  r_out0 <= '0;
                  r_out1 <= '0;
               end
            end
            RESULT: if (r_ready) begin
               state <= LOAD;
               s_ready <= 1'b1;
               r_valid <= 1'b0;
               got0 <= 1'b0;
               got1 <= 1'b0;
            end
            default: state <= LOAD;
         endcase
      end
   end
endmodule
